// File: rtl/demo_counter_pkg.sv
// Shared constants for the demo counter bank: per-channel counting modes
// and the width of the mode field.
package demo_counter_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_UP      = 2'd0;
  localparam logic [MODE_W-1:0] MODE_DOWN    = 2'd1;
  localparam logic [MODE_W-1:0] MODE_MOD     = 2'd2;
  localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'd3;

endpackage

// File: rtl/demo_counter_chan.sv
// One counter channel: clear > load > step > hold, four counting modes and a
// registered terminal-count pulse aligned with the wrapped/terminal count.
module demo_counter_chan
  import demo_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              enable,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  limit,
  input  logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  count,
  output logic              tc
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic             step;

  assign count_inc = count_q + ONE;
  assign count_dec = count_q - ONE;
  assign step      = run && enable;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (step) begin
      unique case (mode)
        MODE_UP: begin
          count_d = count_inc;
          tc_d    = (count_q == MAX_VAL);
        end
        MODE_DOWN: begin
          count_d = count_dec;
          tc_d    = (count_q == '0);
        end
        MODE_MOD: begin
          // Also catches a loaded value already beyond the limit.
          if (count_q >= limit) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end
        MODE_ONESHOT: begin
          if (count_q < limit) begin
            count_d = count_inc;
            tc_d    = (count_inc == limit);
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: rtl/demo_counter_bank.sv
// Bank of NUM_CH independent counters gated by a synchronised and qualified
// clock-wizard lock; lives in the generated clock domain.
module demo_counter_bank
  import demo_counter_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int LOCK_WAIT = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      locked,
  input  logic [NUM_CH-1:0]         enable,
  input  logic [NUM_CH-1:0]         clear,
  input  logic [NUM_CH-1:0]         load,
  input  logic [NUM_CH*WIDTH-1:0]   load_val,
  input  logic [NUM_CH*WIDTH-1:0]   limit,
  input  logic [NUM_CH*MODE_W-1:0]  mode,
  output logic [NUM_CH*WIDTH-1:0]   count,
  output logic [NUM_CH-1:0]         tc,
  output logic                      run
);

  localparam int QW = $clog2(LOCK_WAIT + 1);
  localparam logic [QW-1:0] QUAL_ONE = QW'(1);
  localparam logic [QW-1:0] QUAL_MAX = QW'(LOCK_WAIT);
  localparam logic [QW-1:0] QUAL_ARM = QW'(LOCK_WAIT - 1);

  logic [1:0]    sync_q, sync_d;
  logic [QW-1:0] qual_q, qual_d;
  logic          run_q, run_d;
  logic          locked_s;

  assign locked_s = sync_q[1];

  // run rises on the edge where the qualifier completes LOCK_WAIT cycles,
  // and drops one edge after locked_s is seen low.
  always_comb begin
    sync_d = {sync_q[0], locked};
    qual_d = qual_q;
    if (!locked_s) begin
      qual_d = '0;
    end else if (qual_q != QUAL_MAX) begin
      qual_d = qual_q + QUAL_ONE;
    end
    run_d = locked_s && (qual_q >= QUAL_ARM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      qual_q <= '0;
      run_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      qual_q <= qual_d;
      run_q  <= run_d;
    end
  end

  assign run = run_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    demo_counter_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .run      (run_q),
      .enable   (enable[i]),
      .clear    (clear[i]),
      .load     (load[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .limit    (limit[i*WIDTH +: WIDTH]),
      .mode     (mode[i*MODE_W +: MODE_W]),
      .count    (count[i*WIDTH +: WIDTH]),
      .tc       (tc[i])
    );
  end

endmodule

// File: tb/tb_demo_counter_bank.sv
// Scoreboard bench for demo_counter_bank: a behavioural model predicts each
// cycle's outputs into a queue, a monitor pops and compares.
module tb_demo_counter_bank;

  localparam int NUM_CH    = 4;
  localparam int WIDTH     = 8;
  localparam int LOCK_WAIT = 4;
  localparam int MAXV      = 1 << WIDTH;

  logic                     clk;
  logic                     reset_n;
  logic                     locked;
  logic [NUM_CH-1:0]        enable;
  logic [NUM_CH-1:0]        clear;
  logic [NUM_CH-1:0]        load;
  logic [NUM_CH*WIDTH-1:0]  load_val;
  logic [NUM_CH*WIDTH-1:0]  limit;
  logic [NUM_CH*2-1:0]      mode;
  logic [NUM_CH*WIDTH-1:0]  count;
  logic [NUM_CH-1:0]        tc;
  logic                     run;

  demo_counter_bank #(
    .NUM_CH    (NUM_CH),
    .WIDTH     (WIDTH),
    .LOCK_WAIT (LOCK_WAIT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .locked   (locked),
    .enable   (enable),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .mode     (mode),
    .count    (count),
    .tc       (tc),
    .run      (run)
  );

  typedef struct {
    logic [NUM_CH*WIDTH-1:0] cnt;
    logic [NUM_CH-1:0]       tc;
    logic                    run;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt[NUM_CH];
  bit   m_run;
  bit   hist[$];
  int   n_checks;
  int   n_fail;

  logic [NUM_CH-1:0]       s_en, s_clr, s_ld;
  logic [NUM_CH*WIDTH-1:0] s_lv, s_lim;
  logic [NUM_CH*2-1:0]     s_md;
  logic                    s_lk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic modelReset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_run = 1'b0;
    hist.delete();
  endtask

  // Drives one cycle of inputs and predicts the outputs after the next edge.
  task automatic applyStimulus(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] clr,
                               input logic [NUM_CH-1:0] ld, input logic [NUM_CH*WIDTH-1:0] lv,
                               input logic [NUM_CH*WIDTH-1:0] lim, input logic [NUM_CH*2-1:0] md,
                               input logic lk);
    exp_t e;
    int   c, l, nxt, n, first;
    bit   t;
    @(negedge clk);
    enable = en; clear = clr; load = ld; load_val = lv; limit = lim; mode = md; locked = lk;
    @(posedge clk);
    hist.push_back(lk);
    e.tc  = '0;
    e.cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c   = m_cnt[i];
      l   = int'(lim[i*WIDTH +: WIDTH]);
      nxt = c;
      t   = 1'b0;
      if (clr[i]) nxt = 0;
      else if (ld[i]) nxt = int'(lv[i*WIDTH +: WIDTH]);
      else if (m_run && en[i]) begin
        case (int'(md[i*2 +: 2]))
          0: begin nxt = (c + 1) % MAXV; t = (nxt == 0); end
          1: begin nxt = (c + MAXV - 1) % MAXV; t = (c == 0); end
          2: begin
            if (c >= l) begin nxt = 0; t = 1'b1; end
            else nxt = c + 1;
          end
          default: begin
            if (c < l) begin nxt = c + 1; t = (nxt == l); end
          end
        endcase
      end
      m_cnt[i] = nxt;
      e.tc[i]  = t;
      e.cnt[i*WIDTH +: WIDTH] = WIDTH'(nxt);
    end
    // run after edge n: locked sampled high on every edge n-LOCK_WAIT-1 .. n-2.
    n     = hist.size();
    first = n - LOCK_WAIT - 1;
    m_run = (first >= 1);
    for (int k = first; k <= n - 2; k++) begin
      if (k < 1 || !hist[k-1]) m_run = 1'b0;
    end
    e.run = m_run;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) applyStimulus(s_en, s_clr, s_ld, s_lv, s_lim, s_md, s_lk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("count", 64'(count), 64'(e.cnt));
        checkOutput("tc", 64'(tc), 64'(e.tc));
        checkOutput("run", 64'(run), 64'(e.run));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    n_checks = 0;
    n_fail   = 0;
    modelReset();
    s_en = '0; s_clr = '0; s_ld = '0; s_lv = '0; s_lim = '0; s_md = '0; s_lk = 1'b1;
    reset_n = 1'b0;
    enable = '0; clear = '0; load = '0; load_val = '0; limit = '0; mode = '0; locked = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_run", 64'(run), 64'd0);
    reset_n = 1'b1;

    $display("[TB] lock qualification and UP counting");
    s_en = '1;
    tick(10);

    $display("[TB] UP wrap on ch0");
    s_en = 4'h1; s_ld = 4'h1; s_lv = 32'h0000_00FE;
    tick(1);
    s_ld = '0;
    tick(1);
    #2;
    checkOutput("up_ff", 64'(count[7:0]), 64'hFF);
    checkOutput("up_ff_tc", 64'(tc[0]), 64'd0);
    tick(1);
    #2;
    checkOutput("up_wrap", 64'(count[7:0]), 64'h00);
    checkOutput("up_wrap_tc", 64'(tc[0]), 64'd1);

    $display("[TB] DOWN / MOD / ONESHOT");
    s_clr = '1; s_en = '1;
    tick(1);
    s_clr = '0; s_md = 8'hE4; s_lim = 32'h0503_0000; s_en = 4'hE;
    tick(8);
    #2;
    checkOutput("oneshot_hold", 64'(count[31:24]), 64'd5);
    checkOutput("oneshot_hold_tc", 64'(tc[3]), 64'd0);
    s_clr = 4'h8;
    tick(1);
    s_clr = '0;
    tick(3);

    $display("[TB] priority checks");
    s_clr = '1; s_ld = '1; s_en = '1; s_lv = 32'hA5A5_A5A5;
    tick(1);
    #2;
    checkOutput("clr_over_load", 64'(count), 64'd0);
    s_clr = '0;
    tick(1);
    #2;
    checkOutput("load_no_step", 64'(count), 64'hA5A5_A5A5);
    s_ld = '0; s_md = '0;
    tick(2);

    $display("[TB] lock drop and recovery");
    s_lk = 1'b0;
    tick(6);
    s_lk = 1'b1;
    tick(LOCK_WAIT + 5);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 400; k++) begin
      if (k % 25 == 0) begin
        s_md = NUM_CH*2'($urandom);
        for (int i = 0; i < NUM_CH; i++) begin
          s_lim[i*WIDTH +: WIDTH] = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
        end
      end
      s_en = NUM_CH'($urandom);
      for (int i = 0; i < NUM_CH; i++) begin
        s_clr[i] = ($urandom_range(0, 15) == 0);
        s_ld[i]  = ($urandom_range(0, 15) == 0);
      end
      s_lv = NUM_CH*WIDTH'($urandom);
      if (s_lk) s_lk = ($urandom_range(0, 59) != 0);
      else      s_lk = ($urandom_range(0, 3) == 0);
      tick(1);
    end

    $display("[TB] async reset mid-count");
    s_clr = '0; s_ld = '0; s_md = '0; s_en = '1; s_lk = 1'b1;
    tick(LOCK_WAIT + 8);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async_count", 64'(count), 64'd0);
    checkOutput("async_tc", 64'(tc), 64'd0);
    checkOutput("async_run", 64'(run), 64'd0);
    modelReset();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    tick(LOCK_WAIT + 6);

    repeat (2) @(posedge clk);
    #2;
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demo_counter_bank.md
Name: demo_counter_bank

Overview:
- Parametrised successor of the single 8-bit demo counter.
- NUM_CH independent counters of WIDTH bits, each with a runtime-selectable mode (up-wrap, down-wrap, modulo, one-shot), synchronous load/clear and a terminal-count pulse.
- Counting is gated by a qualified version of the clock-wizard `locked` signal. `locked` is synchronised and must stay high for LOCK_WAIT cycles before counting starts.
- Sits directly downstream of the clock wizard, in the generated clock domain.

Parameters:
- NUM_CH, 4, number of counter channels (>=1).
- WIDTH, 8, bits per counter (>=2).
- LOCK_WAIT, 16, consecutive synchronised-locked cycles required before run asserts (>=1).

Ports:
- clk  in  1  generated clock (clock-wizard output domain).
- reset_n  in  1  asynchronous, active-low reset.
- locked  in  1  clock-wizard lock; asynchronous to clk.
- enable  in  NUM_CH  per-channel count enable.
- clear  in  NUM_CH  per-channel synchronous clear.
- load  in  NUM_CH  per-channel synchronous load.
- load_val  in  NUM_CH*WIDTH  packed load values; channel i at [i*WIDTH +: WIDTH].
- limit  in  NUM_CH*WIDTH  packed terminal values, used by MOD and ONESHOT.
- mode  in  NUM_CH*2  packed 2-bit mode per channel.
- count  out  NUM_CH*WIDTH  packed registered counter values.
- tc  out  NUM_CH  one-cycle terminal-count pulse per channel.
- run  out  1  qualified lock; counting is permitted while high.

Behaviour:
- Reset (reset_n low, asynchronous): count=0, tc=0, run=0, sync flops=0, lock qualifier=0. All state is released on the first clk edge after reset_n rises.
- Lock sync: 2-flop synchroniser produces locked_s.
- Lock qualifier: saturating counter of consecutive cycles with locked_s high; cleared whenever locked_s is low.
- run assertion: run goes high at the (LOCK_WAIT+2)th rising edge at which locked is sampled high, counting the first sample as 1.
- run deassertion: run goes low at the 3rd edge after locked is first sampled low. The qualifier restarts from 0.
- A locked glitch shorter than the sync window may be missed; this is acceptable.
- Channel update priority, evaluated per edge: clear > load > step > hold.
  - clear and load act regardless of run and enable.
  - A step occurs only when run=1 and enable[i]=1.
- Mode 0, UP: count+1; max (2^WIDTH-1) wraps to 0 with tc=1.
- Mode 1, DOWN: count-1; 0 wraps to max with tc=1.
- Mode 2, MOD: if count >= limit, next=0 with tc=1; else count+1.
  - limit=0 gives count held at 0 and tc every stepping cycle.
  - A loaded value above limit returns to 0 on the next step.
- Mode 3, ONESHOT: if count < limit, count+1. tc=1 on the step that makes count==limit.
  - At count >= limit the channel holds with no further tc, including with enable high.
  - clear or load re-arms the channel.
  - limit=0: no step and no tc. A one-shot to 0 is defined as already complete.
- tc is registered and high exactly in the cycle in which count shows the wrapped or terminal value. It is 0 on clear/load cycles and when not stepping.
- Mode or limit change mid-count takes effect on the next step; count is preserved.
- run falling mid-count: all counts hold, tc=0; counting resumes from the held value once run re-asserts.
- Arithmetic is modulo 2^WIDTH unsigned; no sign handling.
- Latency: 1 cycle from enable/clear/load to count.

Decomposition:
- Package demo_counter_pkg:
  - mode localparams MODE_UP=2'd0, MODE_DOWN=2'd1, MODE_MOD=2'd2, MODE_ONESHOT=2'd3;
  - mode width constant MODE_W=2.
- Sub-module demo_counter_chan: one WIDTH-bit channel (clear/load/step/mode logic, tc register), instantiated NUM_CH times in a generate loop.
- The top level holds the synchroniser, lock qualifier, run register and port packing.

Test Plan:
- Reset and lock qualify (LOCK_WAIT=4): hold reset_n low, locked=1, then release; enable=all 1. The tests require:
  - count=0 and run=0 through the first 5 sampling edges;
  - run=1 after edge 6;
  - channels increment from the following edge.
- UP wrap, ch0, WIDTH=8: load 8'hFE, then step 2 cycles. Require count 8'hFF then 8'h00, with tc[0]=1 only in the 8'h00 cycle.
- DOWN and MOD together:
  - ch1 DOWN from 0: first step gives 8'hFF with tc[1]=1.
  - ch2 MOD limit=3 from 0: sequence 1,2,3,0,1, with tc[2]=1 only at the 0.
- ONESHOT, ch3 limit=5: after 5 steps count=5 with a single tc. 3 further enabled cycles keep count=5, tc=0. clear gives count=0, then stepping resumes.
- Priority and gating:
  - clear+load+enable in the same cycle gives count=0.
  - load+enable gives load_val with no step.
  - Drop locked while counting: counts freeze and run=0 at the 3rd edge. Re-raising locked resumes after LOCK_WAIT+2 edges from the held value.
- Async reset mid-count: assert reset_n low between edges. count, tc and run go to 0 immediately, without waiting for a clk edge.
